// File: rtl/cla_seq_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, with the trial
// subtract done as a two's-complement add on 4-bit carry-lookahead groups.
module cla_seq_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned NG = WIDTH / 4;
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   t;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] sub_g;
  logic [WIDTH-1:0] sub_p;
  logic [WIDTH:0]   sub_c;
  logic [WIDTH-1:0] diff;
  logic             grp_g;
  logic             grp_p;
  logic             no_borrow;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Shifted partial remainder with the next dividend bit appended
  assign t = {r_q, q_q[WIDTH-1]};

  // T - D as T + ~D + 1: lookahead inside each 4-bit group, group carries ripple
  always_comb begin
    sub_b    = ~d_q;
    sub_g    = t[WIDTH-1:0] & sub_b;
    sub_p    = t[WIDTH-1:0] ^ sub_b;
    sub_c    = '0;
    sub_c[0] = 1'b1;
    grp_g    = 1'b0;
    grp_p    = 1'b0;
    for (int k = 0; k < NG; k++) begin
      sub_c[4*k+1] = sub_g[4*k] | (sub_p[4*k] & sub_c[4*k]);
      sub_c[4*k+2] = sub_g[4*k+1] | (sub_p[4*k+1] & sub_g[4*k])
                   | (sub_p[4*k+1] & sub_p[4*k] & sub_c[4*k]);
      sub_c[4*k+3] = sub_g[4*k+2] | (sub_p[4*k+2] & sub_g[4*k+1])
                   | (sub_p[4*k+2] & sub_p[4*k+1] & sub_g[4*k])
                   | (sub_p[4*k+2] & sub_p[4*k+1] & sub_p[4*k] & sub_c[4*k]);
      grp_g = sub_g[4*k+3] | (sub_p[4*k+3] & sub_g[4*k+2])
            | (sub_p[4*k+3] & sub_p[4*k+2] & sub_g[4*k+1])
            | (sub_p[4*k+3] & sub_p[4*k+2] & sub_p[4*k+1] & sub_g[4*k]);
      grp_p = &sub_p[4*k +: 4];
      sub_c[4*k+4] = grp_g | (grp_p & sub_c[4*k]);
    end
    diff = sub_p ^ sub_c[WIDTH-1:0];
    // Top operand bit of ~{0,D} is 1, so the final carry is T[W] | c[W]
    no_borrow = t[WIDTH] | sub_c[WIDTH];
  end

  // A kept remainder is always below D, so its bit WIDTH is zero and need not be stored
  assign r_next = no_borrow ? diff : t[WIDTH-1:0];
  assign q_next = {q_q[WIDTH-2:0], no_borrow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r_q         <= '0;
      q_q         <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              r_q   <= '0;
              q_q   <= dividend;
              d_q   <= divisor;
              cnt_q <= '0;
            end
          end
        end
        RUN: begin
          r_q   <= r_next;
          q_q   <= q_next;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/cla_seq_divider.md
# cla_seq_divider

Sequential unsigned restoring divider: the inverse of the team's 4-bit carry-lookahead adder datapath. It produces one quotient bit per clock by trial-subtracting the divisor from a shifting partial remainder. The subtract is a two's-complement add (inverted divisor, carry-in 1) built from 4-bit lookahead groups with group generate/propagate. The block sits beside the CLA adder in the arithmetic unit and uses a start/busy/done handshake.

## Interface
- WIDTH, 8, operand/result width in bits; a multiple of 4 so the subtractor tiles into 4-bit lookahead groups.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request; sampled only when the block is not busy.
- dividend  in  WIDTH  unsigned dividend; captured on an accepted start.
- divisor  in  WIDTH  unsigned divisor; captured on an accepted start.
- busy  out  1  high while a division is in progress.
- done  out  1  one-cycle pulse; the results are valid from this cycle on.
- quotient  out  WIDTH  registered result.
- remainder  out  WIDTH  registered result.
- div_by_zero  out  1  registered flag; valid with done.

## Operation
- States:
  - IDLE: not busy, no done.
  - RUN: busy=1.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Accept:
  - start is accepted in IDLE or DONE.
  - start is ignored in RUN; captured operands stay unchanged.
- On an accepted start with divisor==0:
  - Next state is DONE.
  - quotient = all ones; remainder = dividend; div_by_zero = 1.
- On an accepted start with divisor!=0:
  - Load working registers: R = 0 (WIDTH+1 bits), Q = dividend, D = divisor, count = 0.
  - Next state is RUN.
- Each RUN cycle:
  - Form T = {R[WIDTH-1:0], Q[WIDTH-1]} (WIDTH+1 bits).
  - Compute T + ~{0,D} + 1 with the lookahead adder. The carry-out is the no-borrow bit.
  - If carry=1: R = difference and the Q LSB shifts in as 1.
  - If carry=0: R = T and the Q LSB shifts in as 0.
  - Q shifts left by one on every RUN cycle.
  - count increments on every RUN cycle.
- When count reaches WIDTH-1, the final iteration occurs and the block moves to DONE. In the same edge:
  - quotient ← final Q.
  - remainder ← final R[WIDTH-1:0].
  - div_by_zero ← 0.
- The quotient, remainder and div_by_zero outputs change only on the completion edge. They hold their previous values throughout RUN and IDLE.
- Invariant checked by the bench: dividend == quotient*divisor + remainder, with remainder < divisor (divisor != 0).

## Timing
- Accepted start at edge E0:
  - busy=1 from E0 through the cycle before the completion edge.
  - Completion edge is E0+WIDTH.
  - done is high for the single cycle following E0+WIDTH; busy=0 in that cycle.
- Divide-by-zero: done is high in the cycle after E0 and busy never asserts.
- Back-to-back operation:
  - A start in the done cycle is accepted. busy=1 the next cycle; done drops.
  - Throughput is one result per WIDTH+1 cycles.
- Reset:
  - rst_n low at any time, including mid-RUN, forces immediately: state=IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, working registers=0.
  - The first start is accepted on the first edge after rst_n rises.
- A start held high continuously restarts each time the block returns to DONE/IDLE.
- All outputs come directly from flops; no combinational path from inputs to outputs.
- Subtractor critical path: WIDTH/4 lookahead groups; carries ripple between groups.

## Test plan
- Basic division: WIDTH=8, dividend=100, divisor=7, start at E0.
  - busy is high for 8 cycles.
  - done pulses after E0+8 with quotient=14, remainder=2, div_by_zero=0.
- Extreme values:
  - 255/1 → quotient=255, remainder=0.
  - 255/255 → quotient=1, remainder=0.
  - 5/9 → quotient=0, remainder=5.
- Divide by zero: dividend=77, divisor=0.
  - done pulses one cycle after start.
  - quotient=0xFF, remainder=77, div_by_zero=1, busy never high.
- Start while busy: start 200/3, then pulse start with 10/2 during RUN.
  - The second start is ignored; the result is quotient=66, remainder=2 at E0+8.
  - Then assert start in the done cycle with 10/2. Expect quotient=5, remainder=0 exactly 9 cycles after the first done.
- Reset mid-operation: start 123/4, drop rst_n at cycle 3.
  - All outputs read 0 asynchronously; no done follows.
  - After release, 123/4 yields quotient=30, remainder=3.
- Random sweep: 2000 random operand pairs, divisor != 0.
  - Check the invariant and the WIDTH-cycle latency on every result.
  - Check that outputs stay stable during busy.
